// File: rtl/mem_stage_if.sv
//============================================================================
// Module      : mem_stage_if
// Description : Memory bus between the MEM pipeline stage (master) and the
//               data memory / bus fabric (slave).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
//============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage. Issues one bus access per load/store,
//               stalls upstream until ack, aligns/extends load data, and
//               reports misalignment and bus timeouts as one-cycle pulses.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_stage (
    input  logic         CLK,
    input  logic         Reset,

    input  logic         in_valid,
    input  logic         in_MemRead,
    input  logic         in_MemWrite,
    input  logic         in_RegWrite,
    input  logic         in_MemtoReg,
    input  logic [1:0]   in_Size,
    input  logic         in_Unsigned,
    input  logic [31:0]  in_ALUOut,
    input  logic [31:0]  in_WriteData,
    input  logic [4:0]   in_WriteReg,

    output logic         Stall,

    mem_stage_if.master  bus,

    output logic         RegWrite,
    output logic         MemtoReg,
    output logic [31:0]  ALUOut,
    output logic [31:0]  ReadData,
    output logic [4:0]   WriteReg,

    output logic         Misalign,
    output logic         BusErr,
    output logic [31:0]  BadAddr
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_BUSY     = 1'b1;
    localparam logic [1:0] c_SZ_BYTE  = 2'b00;
    localparam logic [1:0] c_SZ_HALF  = 2'b01;
    // Last unacknowledged BUSY cycle: the counter would reach 255 at its edge.
    localparam logic [7:0] c_WAIT_LAST = 8'd254;

    logic [0:0]  r_state;
    logic [7:0]  r_wait_cnt;

    // Access latched at issue and held for the whole bus transaction
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_lat_regwrite;
    logic        r_lat_memtoreg;
    logic [4:0]  r_lat_writereg;

    logic        r_regwrite;
    logic        r_memtoreg;
    logic [31:0] r_aluout;
    logic [31:0] r_readdata;
    logic [4:0]  r_writereg;
    logic        r_misalign;
    logic        r_buserr;
    logic [31:0] r_badaddr;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_issue;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_mem_op   = in_valid && (in_MemRead || in_MemWrite);
    assign w_misalign = ((in_Size == c_SZ_HALF) && in_ALUOut[0]) ||
                        (in_Size[1] && (in_ALUOut[1:0] != 2'b00));
    assign w_issue    = (r_state == c_IDLE) && w_mem_op && !w_misalign;
    assign w_timeout  = (r_state == c_BUSY) && !bus.mem_ack &&
                        (r_wait_cnt == c_WAIT_LAST);

    // Releasing upstream on the timeout cycle retires the faulting instruction.
    assign Stall = w_issue ||
                   ((r_state == c_BUSY) && !bus.mem_ack && !w_timeout);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in_WriteData;
        case (in_Size)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << in_ALUOut[1:0];
                w_wdata = {4{in_WriteData[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = in_ALUOut[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{in_WriteData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = in_WriteData;
            end
        endcase
    end

    assign w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_load = bus.mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default:   w_load = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state        <= c_IDLE;
            r_wait_cnt     <= 8'd0;
            r_addr         <= 32'd0;
            r_we           <= 1'b0;
            r_be           <= 4'd0;
            r_wdata        <= 32'd0;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_lat_regwrite <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_writereg <= 5'd0;
            r_regwrite     <= 1'b0;
            r_memtoreg     <= 1'b0;
            r_aluout       <= 32'd0;
            r_readdata     <= 32'd0;
            r_writereg     <= 5'd0;
            r_misalign     <= 1'b0;
            r_buserr       <= 1'b0;
            r_badaddr      <= 32'd0;
        end else begin
            // Bubble unless a branch below produces a result.
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluout   <= 32'd0;
            r_readdata <= 32'd0;
            r_writereg <= 5'd0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_wait_cnt <= 8'd0;
                    if (in_valid && !w_mem_op) begin
                        r_regwrite <= in_RegWrite;
                        r_memtoreg <= in_MemtoReg;
                        r_aluout   <= in_ALUOut;
                        r_writereg <= in_WriteReg;
                    end
                    if (w_mem_op && w_misalign) begin
                        r_misalign <= 1'b1;
                        r_badaddr  <= in_ALUOut;
                    end
                    if (w_issue) begin
                        r_addr         <= in_ALUOut;
                        r_we           <= in_MemWrite;
                        r_be           <= w_be;
                        r_wdata        <= w_wdata;
                        r_size         <= in_Size;
                        r_unsigned     <= in_Unsigned;
                        r_lat_regwrite <= in_RegWrite;
                        r_lat_memtoreg <= in_MemtoReg;
                        r_lat_writereg <= in_WriteReg;
                        r_state        <= c_BUSY;
                    end
                end

                c_BUSY: begin
                    if (bus.mem_ack) begin
                        r_regwrite <= r_lat_regwrite;
                        r_memtoreg <= r_lat_memtoreg;
                        r_aluout   <= r_addr;
                        r_readdata <= r_we ? 32'd0 : w_load;
                        r_writereg <= r_lat_writereg;
                        r_wait_cnt <= 8'd0;
                        r_state    <= c_IDLE;
                    end else if (w_timeout) begin
                        r_buserr   <= 1'b1;
                        r_badaddr  <= r_addr;
                        r_wait_cnt <= 8'd0;
                        r_state    <= c_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = (r_state == c_BUSY);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_be    = r_be;
    assign bus.mem_wdata = r_wdata;

    assign RegWrite = r_regwrite;
    assign MemtoReg = r_memtoreg;
    assign ALUOut   = r_aluout;
    assign ReadData = r_readdata;
    assign WriteReg = r_writereg;
    assign Misalign = r_misalign;
    assign BusErr   = r_buserr;
    assign BadAddr  = r_badaddr;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with directed vectors.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid, in_MemRead, in_MemWrite, in_RegWrite, in_MemtoReg, in_Unsigned;
    logic [1:0]  in_Size;
    logic [31:0] in_ALUOut, in_WriteData;
    logic [4:0]  in_WriteReg;
    logic        Stall, RegWrite, MemtoReg, Misalign, BusErr;
    logic [31:0] ALUOut, ReadData, BadAddr;
    logic [4:0]  WriteReg;

    mem_stage_if bus ();

    mem_stage dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .in_valid     (in_valid),
        .in_MemRead   (in_MemRead),
        .in_MemWrite  (in_MemWrite),
        .in_RegWrite  (in_RegWrite),
        .in_MemtoReg  (in_MemtoReg),
        .in_Size      (in_Size),
        .in_Unsigned  (in_Unsigned),
        .in_ALUOut    (in_ALUOut),
        .in_WriteData (in_WriteData),
        .in_WriteReg  (in_WriteReg),
        .Stall        (Stall),
        .bus          (bus),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .ALUOut       (ALUOut),
        .ReadData     (ReadData),
        .WriteReg     (WriteReg),
        .Misalign     (Misalign),
        .BusErr       (BusErr),
        .BadAddr      (BadAddr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wr;
        logic        mis;
        logic        berr;
        logic [31:0] bad;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_act, mon_exp;
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(logic rw, logic mtr, logic [31:0] alu, logic [31:0] rd,
                                logic [4:0] wr, logic mis, logic berr, logic [31:0] bad);
        exp_t e;
        e.rw = rw; e.mtr = mtr; e.alu = alu; e.rd = rd;
        e.wr = wr; e.mis = mis; e.berr = berr; e.bad = bad;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every non-bubble output or fault pulse is matched against the queue.
    always @(negedge CLK) begin
        if (RegWrite || MemtoReg || Misalign || BusErr) begin
            mon_act = mk(RegWrite, MemtoReg, ALUOut, ReadData, WriteReg, Misalign, BusErr,
                         (Misalign || BusErr) ? BadAddr : 32'h0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h want none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL output: got %h want %h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_MemRead = 0; in_MemWrite = 0; in_RegWrite = 0; in_MemtoReg = 0;
        in_Size = 2'b00; in_Unsigned = 0; in_ALUOut = 0; in_WriteData = 0; in_WriteReg = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
    endtask

    task automatic present(logic rd, logic wr, logic rw, logic mtr, logic [1:0] sz, logic uns,
                           logic [31:0] alu, logic [31:0] wd, logic [4:0] wreg);
        in_valid = 1; in_MemRead = rd; in_MemWrite = wr; in_RegWrite = rw; in_MemtoReg = mtr;
        in_Size = sz; in_Unsigned = uns; in_ALUOut = alu; in_WriteData = wd; in_WriteReg = wreg;
    endtask

    task automatic alu_op(logic mtr, logic [31:0] alu, logic [4:0] wr);
        present(0, 0, 1, mtr, 2'b10, 0, alu, 32'hFFFF_FFFF, wr);
        exp_q.push_back(mk(1, mtr, alu, 32'h0, wr, 0, 0, 32'h0));
        @(negedge CLK);
        chk("alu_stall", Stall, 0);
        chk("alu_mem_req", bus.mem_req, 0);
        next();
        idle_inputs();
    endtask

    task automatic load_op(logic [1:0] sz, logic uns, logic [31:0] addr, logic [4:0] wr,
                           int waits, logic [31:0] rdata, logic [31:0] exp_rd, logic [3:0] exp_be);
        int stalls;
        stalls = 0;
        present(1, 0, 1, 1, sz, uns, addr, 32'h0, wr);
        exp_q.push_back(mk(1, 1, addr, exp_rd, wr, 0, 0, 32'h0));
        @(negedge CLK);
        if (Stall) stalls++;
        chk("ld_req_idle", bus.mem_req, 0);
        next();
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            if (Stall) stalls++;
            chk("ld_wait_bubble", RegWrite, 0);
            chk("ld_wait_req", bus.mem_req, 1);
            next();
        end
        bus.mem_ack = 1; bus.mem_rdata = rdata;
        @(negedge CLK);
        chk("ld_ack_stall", Stall, 0);
        chk("ld_ack_bubble", RegWrite, 0);
        chk("ld_addr", bus.mem_addr, {addr[31:2], 2'b00});
        chk("ld_be", bus.mem_be, exp_be);
        chk("ld_we", bus.mem_we, 0);
        chk("ld_stall_cycles", stalls, waits + 1);
        next();
        idle_inputs();
        @(negedge CLK);
        chk("ld_req_done", bus.mem_req, 0);
        next();
    endtask

    task automatic store_op(logic [1:0] sz, logic [31:0] addr, logic [31:0] wd, logic rd_too,
                            logic [3:0] exp_be, logic [31:0] exp_wdata);
        present(rd_too, 1, 0, 0, sz, 0, addr, wd, 5'd0);
        @(negedge CLK);
        chk("st_issue_stall", Stall, 1);
        next();
        @(negedge CLK);
        chk("st_req", bus.mem_req, 1);
        chk("st_we", bus.mem_we, 1);
        chk("st_addr", bus.mem_addr, {addr[31:2], 2'b00});
        chk("st_be", bus.mem_be, exp_be);
        chk("st_wdata", bus.mem_wdata, exp_wdata);
        next();
        bus.mem_ack = 1;
        @(negedge CLK);
        chk("st_ack_stall", Stall, 0);
        chk("st_wdata_hold", bus.mem_wdata, exp_wdata);
        next();
        idle_inputs();
        @(negedge CLK);
        chk("st_req_done", bus.mem_req, 0);
        next();
    endtask

    task automatic misalign_op(logic [1:0] sz, logic [31:0] addr, logic [4:0] wr);
        present(1, 0, 1, 1, sz, 0, addr, 32'h0, wr);
        exp_q.push_back(mk(0, 0, 32'h0, 32'h0, 5'd0, 1, 0, addr));
        @(negedge CLK);
        chk("mis_stall", Stall, 0);
        chk("mis_req_issue", bus.mem_req, 0);
        next();
        idle_inputs();
        @(negedge CLK);
        chk("mis_req_after", bus.mem_req, 0);
        next();
        @(negedge CLK);
        chk("mis_pulse_end", Misalign, 0);
        next();
    endtask

    task automatic timeout_op(logic ack_last, logic [31:0] addr, logic [4:0] wr, logic [31:0] rdata);
        int last;
        last = 0;
        present(1, 0, 1, 1, 2'b10, 0, addr, 32'h0, wr);
        if (ack_last) exp_q.push_back(mk(1, 1, addr, rdata, wr, 0, 0, 32'h0));
        else          exp_q.push_back(mk(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, addr));
        @(negedge CLK);
        next();
        for (int k = 1; k <= 400; k++) begin
            if (ack_last && k == 255) begin
                bus.mem_ack = 1; bus.mem_rdata = rdata;
            end
            @(negedge CLK);
            if (!bus.mem_req || !Stall) begin
                last = k;
                break;
            end
            next();
        end
        chk("to_busy_cycles", last, 255);
        chk("to_req_last", bus.mem_req, 1);
        next();
        idle_inputs();
        @(negedge CLK);
        chk("to_req_after", bus.mem_req, 0);
        chk("to_stall_after", Stall, 0);
        next();
    endtask

    initial begin
        Reset = 1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_aluout", ALUOut, 0);
        chk("rst_readdata", ReadData, 0);
        chk("rst_writereg", WriteReg, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_stall", Stall, 0);
        next();
        Reset = 0;

        alu_op(0, 32'h0000_1234, 5'd5);
        alu_op(1, 32'hDEAD_BEEF, 5'd31);
        next();

        load_op(2'b00, 0, 32'h0000_1003, 5'd7,  3, 32'h8012_3456, 32'hFFFF_FF80, 4'b1000);
        load_op(2'b01, 1, 32'h0000_2002, 5'd8,  0, 32'h8765_4321, 32'h0000_8765, 4'b1100);
        load_op(2'b01, 0, 32'h0000_2000, 5'd9,  1, 32'h1234_F00D, 32'hFFFF_F00D, 4'b0011);
        load_op(2'b00, 1, 32'h0000_4001, 5'd10, 2, 32'h0000_A500, 32'h0000_00A5, 4'b0010);
        load_op(2'b10, 0, 32'h0000_5000, 5'd11, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'b1111);
        load_op(2'b11, 0, 32'h0000_5004, 5'd12, 1, 32'h8000_0001, 32'h8000_0001, 4'b1111);
        load_op(2'b00, 0, 32'h0000_1000, 5'd13, 0, 32'hFFFF_FF7F, 32'h0000_007F, 4'b0001);

        store_op(2'b01, 32'h0000_2002, 32'h1234_ABCD, 0, 4'b1100, 32'hABCD_ABCD);
        store_op(2'b00, 32'h0000_0005, 32'h0000_005A, 1, 4'b0010, 32'h5A5A_5A5A);
        store_op(2'b10, 32'h0000_8000, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344);

        misalign_op(2'b10, 32'h0000_3001, 5'd3);
        misalign_op(2'b01, 32'h0000_3003, 5'd4);
        misalign_op(2'b11, 32'h0000_3002, 5'd6);

        // A stray ack while idle must not start or complete anything.
        bus.mem_ack = 1; bus.mem_rdata = 32'h1111_1111;
        @(negedge CLK);
        chk("idle_ack_req", bus.mem_req, 0);
        next();
        idle_inputs();
        @(negedge CLK);
        chk("idle_ack_out", RegWrite, 0);
        next();

        timeout_op(0, 32'h0000_6000, 5'd14, 32'h0);
        timeout_op(1, 32'h0000_6004, 5'd15, 32'h0BAD_F00D);

        // Reset in the second BUSY cycle, coincident with an ack, then a late ack.
        present(1, 0, 1, 1, 2'b10, 0, 32'h0000_7000, 32'h0, 5'd9);
        @(negedge CLK);
        next();
        @(negedge CLK);
        chk("rb_req_busy1", bus.mem_req, 1);
        next();
        Reset = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h5555_5555;
        @(negedge CLK);
        next();
        Reset = 0;
        idle_inputs();
        bus.mem_ack = 1; bus.mem_rdata = 32'h6666_6666;
        @(negedge CLK);
        chk("rb_req", bus.mem_req, 0);
        chk("rb_regwrite", RegWrite, 0);
        chk("rb_aluout", ALUOut, 0);
        chk("rb_readdata", ReadData, 0);
        chk("rb_writereg", WriteReg, 0);
        chk("rb_badaddr", BadAddr, 0);
        chk("rb_mem_addr", bus.mem_addr, 0);
        chk("rb_mem_be", bus.mem_be, 0);
        next();
        bus.mem_ack = 0;
        @(negedge CLK);
        chk("rb_late_ack_req", bus.mem_req, 0);
        chk("rb_late_ack_out", RegWrite, 0);
        next();

        repeat (3) next();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL: CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: Reset  input  1  synchronous, active-high; sampled on CLK rising edge.
REQ-003 SHALL: in_valid  input  1  upstream presents an instruction this cycle.
REQ-004 SHALL: in_MemRead, in_MemWrite, in_RegWrite, in_MemtoReg  input  1 each  control bits from EX.
REQ-005 SHALL: in_Size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 SHALL: in_Unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-007 SHALL: in_ALUOut  input  32  ALU result / effective address.
REQ-008 SHALL: in_WriteData  input  32  store data, right-aligned.
REQ-009 SHALL: in_WriteReg  input  5  destination register.
REQ-010 SHALL: Stall  output  1  upstream holds its inputs while 1.
REQ-011 SHALL: mem_req, mem_we  output  1 each  bus request / write enable.
REQ-012 SHALL: mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 SHALL: mem_be  output  4  byte enables; mem_wdata  output  32  lane-replicated store data.
REQ-014 SHALL: mem_rdata  input  32; mem_ack  input  1  one-cycle completion strobe.
REQ-015 SHALL: RegWrite, MemtoReg  output  1 each; ALUOut, ReadData  output  32 each; WriteReg  output  5  registered outputs to MEM_WB.
REQ-016 SHALL: Misalign, BusErr  output  1 each  one-cycle fault pulses; BadAddr  output  32  faulting address.

Function
REQ-017 SHALL: FSM states IDLE, BUSY; IDLE after reset.
REQ-018 SHALL: a memory op is in_valid && (in_MemRead || in_MemWrite); in_MemWrite takes precedence when both are set.
REQ-019 SHALL: misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 SHALL: IDLE, non-memory valid op: copy RegWrite/MemtoReg/ALUOut/WriteReg to outputs at the next edge; ReadData=0; Stall=0.
REQ-021 SHALL: IDLE, in_valid=0: output bubble (RegWrite=0, MemtoReg=0, WriteReg=0, data 0) at the next edge.
REQ-022 SHALL: IDLE, misaligned memory op: no bus request; bubble output; Misalign=1 and BadAddr=in_ALUOut for exactly the next cycle; Stall=0.
REQ-023 SHALL: IDLE, aligned memory op: Stall=1 combinationally; latch address, be, wdata, size, sign and controls; enter BUSY at the next edge.
REQ-024 SHALL: BUSY: mem_req=1 with latched mem_we/mem_addr/mem_be/mem_wdata held stable; mem_req=0 in IDLE.
REQ-025 SHALL: BUSY, mem_ack=0: Stall=1; bubble output at each edge; 8-bit wait counter increments.
REQ-026 SHALL: BUSY, mem_ack=1: Stall=0; at that edge, load result (or store pass-through, ReadData=0) written to outputs; return to IDLE; counter cleared.
REQ-027 SHALL: byte lane = addr[1:0]; half lane = addr[1]; mem_be: byte 0001<<addr[1:0], half 0011<<(2*addr[1]), word 1111.
REQ-028 SHALL: mem_wdata: byte replicated ×4, half replicated ×2, word unchanged.
REQ-029 SHALL: ReadData: selected lane extended to 32 bits per in_Unsigned; word loads unchanged.
REQ-030 SHALL: counter reaching 255 without ack: drop mem_req; bubble output; BusErr=1 and BadAddr=latched address for one cycle; return to IDLE; Stall=0 in that cycle; upstream instruction is consumed.
REQ-031 SHALL: mem_ack in IDLE is ignored.
REQ-032 SHALL: ack and timeout in the same cycle: ack wins.

Reset
REQ-033 SHALL: Reset=1 forces IDLE; clears counter; all outputs and latches go to 0 at that edge, including mid-BUSY abort (mem_req=0 next cycle).
REQ-034 SHALL: Reset has priority over every other event, including mem_ack.

Verification
REQ-035 SHALL: ALU op, ALUOut=0x1234, WriteReg=5, RegWrite=1 -> next cycle outputs match; Stall never 1.
REQ-036 SHALL: lb at 0x1003, unsigned=0, mem_rdata=0x80xxxxxx, ack after 3 wait cycles -> Stall high 4 cycles, then ReadData=0xFFFFFF80; 4 bubble outputs precede the result.
REQ-037 SHALL: sh at 0x2002, WriteData=0xABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x2000.
REQ-038 SHALL: lw at 0x3001 -> no mem_req; Misalign=1 for 1 cycle; BadAddr=0x3001; RegWrite=0.
REQ-039 SHALL: lw with no ack -> BusErr=1 after 255 BUSY cycles; mem_req=0 next cycle; Stall=0.
REQ-040 SHALL: Reset asserted in BUSY 2nd cycle -> next cycle mem_req=0, IDLE, all outputs 0; a late mem_ack is ignored.
